// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : alu_pkg
//  Purpose   : alucontrol encodings and legality helper shared by the ALU stage
//  Revision  : 1.0  initial release
// ============================================================================
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_AND = 3'b000;
    localparam alu_op_t ALU_OR  = 3'b001;
    localparam alu_op_t ALU_ADD = 3'b010;
    localparam alu_op_t ALU_SUB = 3'b110;
    localparam alu_op_t ALU_SLT = 3'b111;

    function automatic logic is_legal_alu(input alu_op_t code);
        return (code == ALU_AND) || (code == ALU_OR) || (code == ALU_ADD) ||
               (code == ALU_SUB) || (code == ALU_SLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_stage_if.sv
`default_nettype none
// ============================================================================
//  Interface : alu_exec_stage_if
//  Purpose   : operand input and EX/MEM result slot of the ALU execute stage
//  Revision  : 1.0  initial release
// ============================================================================
interface alu_exec_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) ();
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    alu_op_t          alucontrol;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, alucontrol, src_a, src_b, flush, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal, op_count
    );

    modport slave (
        input  in_valid, alucontrol, src_a, src_b, flush, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal, op_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module    : alu_core
//  Purpose   : combinational AND/OR/ADD/SUB/SLT with signed-overflow flag
//  Revision  : 1.0  initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          alucontrol,
    output logic [WIDTH-1:0] y,
    output logic             ovf,
    output logic             illegal
);

    logic             w_sub;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    // One adder serves add, sub and slt: sub/slt use a + ~b + 1.
    assign w_sub = (alucontrol == ALU_SUB) || (alucontrol == ALU_SLT);
    assign w_bx  = w_sub ? ~b : b;
    assign w_sum = a + w_bx + {{(WIDTH-1){1'b0}}, w_sub};
    assign w_ovf = (a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        y       = '0;
        ovf     = 1'b0;
        illegal = !is_legal_alu(alucontrol);
        case (alucontrol)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD,
            ALU_SUB: begin
                y   = w_sum;
                ovf = w_ovf;
            end
            ALU_SLT: y[0] = w_sum[WIDTH-1] ^ w_ovf;
            default: y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module    : alu_exec_stage
//  Purpose   : ALU execute stage with registered EX/MEM result slot, flush
//              and retired-operation counter
//  Revision  : 1.0  initial release
// ============================================================================
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_exec_stage_if.slave   bus
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_illegal;
    logic [CNT_W-1:0] r_op_count;

    logic             w_out_valid;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_handshake;
    logic [WIDTH-1:0] w_y;
    logic             w_ovf;
    logic             w_illegal;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a          (bus.src_a),
        .b          (bus.src_b),
        .alucontrol (bus.alucontrol),
        .y          (w_y),
        .ovf        (w_ovf),
        .illegal    (w_illegal)
    );

    assign w_out_valid = (r_state == S_FULL);
    assign w_in_ready  = !w_out_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready && !bus.flush;
    assign w_handshake = w_out_valid && bus.out_ready;

    // Data regs load only on accept; flush leaves them stale since out_valid gates them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (bus.flush) begin
            r_state <= S_EMPTY;
        end else if (w_accept) begin
            r_state    <= S_FULL;
            r_result   <= w_y;
            r_zero     <= (w_y == '0);
            r_overflow <= w_ovf;
            r_illegal  <= w_illegal;
        end else if (w_handshake) begin
            r_state <= S_EMPTY;
        end
    end

    // A flush cycle still counts: the consumer has already sampled the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_handshake) begin
            r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_overflow;
    assign bus.illegal   = r_illegal;
    assign bus.op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module    : tb_alu_exec_stage
//  Purpose   : self-checking bench for alu_exec_stage (vector table, directed
//              handshake/flush/reset sequences, randomized scoreboard)
//  Revision  : 1.0  initial release
// ============================================================================
module tb_alu_exec_stage;

    localparam int     WIDTH = 32;
    localparam int     CNT_W = 32;
    localparam longint MAXS  = 64'sd2147483647;
    localparam longint MINS  = -64'sd2147483648;

    typedef struct {
        logic [2:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        il;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        il;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   exp_cnt;
    exp_t q[$];
    vec_t vecs[10];

    alu_exec_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_exec_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b);
        bus.in_valid   = v;
        bus.alucontrol = c;
        bus.src_a      = a;
        bus.src_b      = b;
    endtask

    // Reference: signed arithmetic on 64-bit integers, overflow = out of 32-bit range.
    function automatic exp_t model(input logic [2:0] c, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t   e;
        longint sa, sb, s;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        s    = 0;
        e.r  = '0;
        e.o  = 1'b0;
        e.il = 1'b0;
        case (c)
            3'b010: begin s = sa + sb; e.r = s[31:0]; e.o = (s > MAXS) || (s < MINS); end
            3'b110: begin s = sa - sb; e.r = s[31:0]; e.o = (s > MAXS) || (s < MINS); end
            3'b000: e.r = a & b;
            3'b001: e.r = a | b;
            3'b111: e.r = (sa < sb) ? 32'd1 : 32'd0;
            default: e.il = 1'b1;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 0;
        rst      = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);

        vecs[0] = '{3'b010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0};
        vecs[1] = '{3'b110, 32'h3,          32'h3,          32'd0,          1'b1, 1'b0, 1'b0};
        vecs[2] = '{3'b010, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1, 1'b0};
        vecs[3] = '{3'b111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0};
        vecs[4] = '{3'b111, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 1'b0};
        vecs[5] = '{3'b111, 32'h8000_0000,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0};
        vecs[6] = '{3'b100, 32'd9,          32'd4,          32'd0,          1'b1, 1'b0, 1'b1};
        vecs[7] = '{3'b000, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0, 1'b0};
        vecs[8] = '{3'b001, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1'b0, 1'b0, 1'b0};
        vecs[9] = '{3'b110, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1, 1'b0};

        repeat (2) tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result",    64'(bus.result),    64'd0);
        check("rst_zero",      64'(bus.zero),      64'd0);
        check("rst_overflow",  64'(bus.overflow),  64'd0);
        check("rst_illegal",   64'(bus.illegal),   64'd0);
        check("rst_op_count",  64'(bus.op_count),  64'd0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Vector table: one op at a time with a free-running consumer.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].code, vecs[i].a, vecs[i].b);
            tick();
            drive(1'b0, 3'b000, 32'd0, 32'd0);
            check($sformatf("vec%0d_valid", i),    64'(bus.out_valid), 64'd1);
            check($sformatf("vec%0d_result", i),   64'(bus.result),    64'(vecs[i].r));
            check($sformatf("vec%0d_zero", i),     64'(bus.zero),      64'(vecs[i].z));
            check($sformatf("vec%0d_overflow", i), 64'(bus.overflow),  64'(vecs[i].o));
            check($sformatf("vec%0d_illegal", i),  64'(bus.illegal),   64'(vecs[i].il));
            tick();
            exp_cnt++;
            check($sformatf("vec%0d_count", i),    64'(bus.op_count),  64'(exp_cnt));
            check($sformatf("vec%0d_drained", i),  64'(bus.out_valid), 64'd0);
        end

        // Backpressure: result held, new input refused, then back-to-back refill.
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b010, 32'd5, 32'd7);
        tick();
        drive(1'b1, 3'b010, 32'd9, 32'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_in_ready", 64'(bus.in_ready),  64'd0);
            check("stall_result",   64'(bus.result),    64'd12);
            check("stall_valid",    64'(bus.out_valid), 64'd1);
            check("stall_count",    64'(bus.op_count),  64'(exp_cnt));
        end
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b010, 32'd1, 32'd1);
        #1;
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        exp_cnt++;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        check("b2b_valid",  64'(bus.out_valid), 64'd1);
        check("b2b_result", 64'(bus.result),    64'd2);
        check("b2b_count",  64'(bus.op_count),  64'(exp_cnt));
        tick();
        exp_cnt++;
        check("b2b_count2", 64'(bus.op_count),  64'(exp_cnt));
        check("b2b_empty",  64'(bus.out_valid), 64'd0);

        // Flush while FULL without consumer: slot empties, nothing counted, input dropped.
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b010, 32'd2, 32'd3);
        tick();
        check("fl_full", 64'(bus.out_valid), 64'd1);
        bus.flush = 1'b1;
        drive(1'b1, 3'b010, 32'd4, 32'd4);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        check("fl_empty",    64'(bus.out_valid), 64'd0);
        check("fl_count",    64'(bus.op_count),  64'(exp_cnt));
        tick();
        check("fl_dropped",  64'(bus.out_valid), 64'd0);
        // Flush with consumer ready: the handshake still counts.
        drive(1'b1, 3'b010, 32'd6, 32'd6);
        tick();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        exp_cnt++;
        bus.flush = 1'b0;
        check("flrdy_empty", 64'(bus.out_valid), 64'd0);
        check("flrdy_count", 64'(bus.op_count),  64'(exp_cnt));

        // Randomized traffic against a one-deep queue model of the slot.
        q.delete();
        for (int i = 0; i < 400; i++) begin
            logic        v, rdy, fl, hs, acc;
            logic [2:0]  c;
            logic [31:0] a, b;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            c   = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            drive(v, c, a, b);
            bus.out_ready = rdy;
            bus.flush     = fl;
            #1;
            check("rnd_in_ready", 64'(bus.in_ready), 64'((q.size() == 0) || rdy));
            hs  = (q.size() != 0) && rdy;
            acc = v && ((q.size() == 0) || rdy) && !fl;
            if (hs) begin
                void'(q.pop_front());
                exp_cnt++;
            end
            if (fl) q.delete();
            else if (acc) q.push_back(model(c, a, b));
            tick();
            check("rnd_valid", 64'(bus.out_valid), 64'(q.size() != 0));
            check("rnd_count", 64'(bus.op_count),  64'(exp_cnt));
            if (q.size() != 0) begin
                check("rnd_result",   64'(bus.result),   64'(q[0].r));
                check("rnd_zero",     64'(bus.zero),     64'(q[0].z));
                check("rnd_overflow", 64'(bus.overflow), 64'(q[0].o));
                check("rnd_illegal",  64'(bus.illegal),  64'(q[0].il));
            end
        end
        bus.flush = 1'b0;

        // Asynchronous reset while FULL: pending result and counter are lost at once.
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b010, 32'd3, 32'd4);
        tick();
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        check("arst_full", 64'(bus.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid",  64'(bus.out_valid), 64'd0);
        check("arst_count",  64'(bus.op_count),  64'd0);
        check("arst_result", 64'(bus.result),    64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_stays_empty", 64'(bus.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
